spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- Synthesizable SPI slave that models an MCP3002-style 2-channel, 10-bit ADC, i.e. the device end of the spi2adc link.
- Runs on sysclk and oversamples adc_cs, adc_sck and sdata_to_adc.
- Decodes the 4-bit config word (start, SGL/DIFF, ODD/SIGN, MSBF) and shifts the selected channel's 10-bit sample out on sdata_from_adc.
- Used on-chip as a loopback ADC stand-in and as the bench partner for spi2adc.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on adc_cs, adc_sck and sdata_to_adc (minimum 2).
- DATA_W, 10, width of conversion data and number of data bits shifted out.

Ports:
- sysclk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset.
- adc_cs  in  1  chip select from master, active low.
- adc_sck  in  1  serial clock from master; idles low.
- sdata_to_adc  in  1  config bits from master, sampled on SCK rising edges.
- sdata_from_adc  out  1  conversion data to master, updated on SCK falling edges.
- sdo_en  out  1  high while the responder drives sdata_from_adc (null bit and data bits).
- ch0_data  in  DATA_W  sample value for channel 0.
- ch1_data  in  DATA_W  sample value for channel 1.
- conv_valid  out  1  one-cycle pulse when the config word is complete and the sample is latched.
- conv_channel  out  1  ODD/SIGN bit of the last config word; valid with conv_valid and held afterwards.
- conv_diff  out  1  1 when SGL/DIFF=0 (differential request); held with conv_channel.
- frame_error  out  1  one-cycle pulse when CS deasserts before the last data bit.

Behaviour:
- Reset (rst_n=0 at a sysclk edge): state=IDLE; sdata_from_adc=0, sdo_en=0, conv_valid=0, conv_channel=0, conv_diff=0, frame_error=0; synchronizers cleared to cs=1, sck=0, sdi=0.
- Edge detect: the registered synchronized signals produce sck_rise, sck_fall, cs_fall and cs_rise pulses. Each pulse appears SYNC_STAGES+1 sysclk after the pin edge.
- Requirement: each SCK half-period and CS setup is at least SYNC_STAGES+3 sysclk.
- IDLE: waits for cs_fall, then goes to START. If CS is already low when reset exits, no frame starts until CS has been seen high.
- START: on each sck_rise, samples sdi. Leading 0s are ignored. A 1 moves to CFG with bit counter=0.
- CFG: on sck_rise, shifts in SGL/DIFF, then ODD/SIGN, then MSBF.
  - On the third bit, in the same cycle: latch shift_reg <= (ODD ? ch1_data : ch0_data); set conv_channel and conv_diff; latch msbf; pulse conv_valid; go to NULL.
- NULL: on the next sck_fall, sdo_en=1 and sdata_from_adc=0. Go to DATA with index=DATA_W-1.
- DATA: on each sck_fall, drive shift_reg[index] and decrement index.
  - After bit 0 has been driven, the next sck_fall goes to TAIL (see optional feature) or DONE.
- DONE: sdata_from_adc=0 and sdo_en=0; extra SCK edges are ignored.
- Any state except IDLE: cs_rise returns to IDLE with sdo_en=0 and sdata_from_adc=0 in the same cycle.
  - frame_error pulses if the state was START-with-start-bit-seen, CFG, NULL, DATA or TAIL.
  - No frame_error pulse from START with no start bit, or from DONE.
- Simultaneous cs_rise with sck_rise or sck_fall: cs_rise wins and the SCK edge is discarded.
- sdata_from_adc and sdo_en are registered outputs. They change one sysclk after the internal sck_fall pulse.
- Frame length (MSBF=1, no leading zeros): 4 config clocks + 1 null + DATA_W data = 15 falling edges to the last bit; the master sends 16 clocks.
- ch0_data and ch1_data are sampled only at the conv_valid cycle. Later input changes do not affect the frame in progress.

Optional Feature:
- Macro ADC_RESP_LSBF_EN.
- Defined: if latched msbf=0, DATA is followed by TAIL. TAIL drives shift_reg[1], [2], ..., [DATA_W-1] on successive sck_fall (LSB-first repeat, B0 not repeated), then goes to DONE.
  - With msbf=1, TAIL is skipped.
- Not defined: the MSBF bit is decoded but ignored, TAIL does not exist, and DONE follows bit 0 regardless of msbf.

Test Plan:
- CS low, SDI bits 1,1,1,1 (ch1, single-ended, MSBF), ch1_data=10'h2A5, 16 SCK at 1 MHz -> conv_valid pulse, conv_channel=1, conv_diff=0; master captures null 0 then 1010100101; sdo_en deasserts after CS high.
- Same frame with bits 1,1,0,1 and ch0_data=10'h3FF, ch1_data=10'h000 -> ten 1s after the null bit; conv_channel=0.
- Three leading 0s before the start bit, ch1_data=10'h155 -> frame decodes correctly, shifted 3 clocks later; no frame_error.
- CS raised after the 6th data bit -> frame_error pulses once, sdo_en=0 within SYNC_STAGES+2 sysclk; next frame with 10'h0F0 returns correct data.
- rst_n low for 1 cycle mid-DATA while CS stays low -> all outputs 0; no frame until CS goes high, then low; following frame correct.
- ADC_RESP_LSBF_EN defined, bits 1,1,1,0, ch1_data=10'h201 -> MSB-first 1000000001, then tail 0,0,0,0,0,0,0,0,1; macro undefined -> tail bits all 0 with sdo_en=0.

Source files
------------

// File: rtl/spi_adc_responder_if.sv
// SPI pin bundle between an spi2adc master and the ADC responder.
// Handshake: there is no valid/ready pair on this link. The master owns
// adc_cs (active low), adc_sck (idles low) and sdata_to_adc. The responder
// samples sdata_to_adc on SCK rising edges. It drives sdata_from_adc after
// SCK falling edges, and only while sdo_en is high.
interface spi_adc_responder_if;
    logic adc_cs;
    logic adc_sck;
    logic sdata_to_adc;
    logic sdata_from_adc;
    logic sdo_en;

    modport master (
        output adc_cs,
        output adc_sck,
        output sdata_to_adc,
        input  sdata_from_adc,
        input  sdo_en
    );

    modport slave (
        input  adc_cs,
        input  adc_sck,
        input  sdata_to_adc,
        output sdata_from_adc,
        output sdo_en
    );
endinterface

// File: rtl/spi_adc_responder.sv
// MCP3002-style 2-channel ADC responder (SPI slave) running on sysclk.
// It oversamples CS, SCK and SDI, decodes start/SGL/ODD/MSBF and shifts
// out a null bit followed by the selected channel's DATA_W-bit sample.
// Optional macro ADC_RESP_LSBF_EN: when MSBF=0, an LSB-first tail
// (bits 1..DATA_W-1) follows the MSB-first word.
module spi_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 10
) (
    input  logic              sysclk,
    input  logic              rst_n,
    spi_adc_responder_if.slave spi,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              conv_valid,
    output logic              conv_channel,
    output logic              conv_diff,
    output logic              frame_error,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CFG   = 3'd2,
        S_NULL  = 3'd3,
        S_DATA  = 3'd4,
        S_DONE  = 3'd5
`ifdef ADC_RESP_LSBF_EN
        , S_TAIL = 3'd6
`endif
    } state_t;

    // Synchronizers, edge-detect history and pulses
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdi_sync_q, fill_q;
    logic cs_prev_q, sck_prev_q, sdi_q, armed_q;
    logic sck_rise_q, sck_fall_q, cs_fall_q, cs_rise_q;
    logic cs_s, sck_s, sdi_s;

    // FSM and datapath state
    state_t            state_q, state_d;
    logic [1:0]        bit_cnt_q, bit_cnt_d;
    logic              sgl_q, sgl_d;
    logic              odd_q, odd_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
`ifdef ADC_RESP_LSBF_EN
    logic              msbf_q, msbf_d;
`endif

    // Registered outputs
    logic sdo_q, sdo_d;
    logic sdo_en_q, sdo_en_d;
    logic conv_valid_q, conv_valid_d;
    logic conv_channel_q, conv_channel_d;
    logic conv_diff_q, conv_diff_d;
    logic frame_error_q, frame_error_d;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // Input synchronizers plus registered edge pulses. fill_q tracks when the
    // synchronizer output holds a real pin sample rather than its reset value,
    // so a CS that is already low when reset exits cannot arm a frame.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            fill_q     <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            sdi_q      <= 1'b0;
            armed_q    <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi.adc_cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi.adc_sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi.sdata_to_adc};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            sdi_q      <= sdi_s;
            armed_q    <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
            sck_rise_q <= sck_s & ~sck_prev_q;
            sck_fall_q <= ~sck_s & sck_prev_q;
            cs_fall_q  <= ~cs_s & cs_prev_q;
            cs_rise_q  <= cs_s & ~cs_prev_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= 2'd0;
            sgl_q          <= 1'b0;
            odd_q          <= 1'b0;
            shift_q        <= '0;
            idx_q          <= '0;
            last_q         <= 1'b0;
`ifdef ADC_RESP_LSBF_EN
            msbf_q         <= 1'b1;
`endif
            sdo_q          <= 1'b0;
            sdo_en_q       <= 1'b0;
            conv_valid_q   <= 1'b0;
            conv_channel_q <= 1'b0;
            conv_diff_q    <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            sgl_q          <= sgl_d;
            odd_q          <= odd_d;
            shift_q        <= shift_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
`ifdef ADC_RESP_LSBF_EN
            msbf_q         <= msbf_d;
`endif
            sdo_q          <= sdo_d;
            sdo_en_q       <= sdo_en_d;
            conv_valid_q   <= conv_valid_d;
            conv_channel_q <= conv_channel_d;
            conv_diff_q    <= conv_diff_d;
            frame_error_q  <= frame_error_d;
        end
    end

    // Next-state and output decode; a CS rise outranks any SCK edge
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        sgl_d          = sgl_q;
        odd_d          = odd_q;
        shift_d        = shift_q;
        idx_d          = idx_q;
        last_d         = last_q;
`ifdef ADC_RESP_LSBF_EN
        msbf_d         = msbf_q;
`endif
        sdo_d          = sdo_q;
        sdo_en_d       = sdo_en_q;
        conv_valid_d   = 1'b0;
        conv_channel_d = conv_channel_q;
        conv_diff_d    = conv_diff_q;
        frame_error_d  = 1'b0;

        if (state_q != S_IDLE && cs_rise_q) begin
            state_d  = S_IDLE;
            sdo_d    = 1'b0;
            sdo_en_d = 1'b0;
            if (state_q == S_CFG || state_q == S_NULL || state_q == S_DATA) begin
                frame_error_d = 1'b1;
            end
`ifdef ADC_RESP_LSBF_EN
            if (state_q == S_TAIL) begin
                frame_error_d = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    sdo_d    = 1'b0;
                    sdo_en_d = 1'b0;
                    if (cs_fall_q && armed_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (sck_rise_q && sdi_q) begin
                        state_d   = S_CFG;
                        bit_cnt_d = 2'd0;
                    end
                end
                S_CFG: begin
                    if (sck_rise_q) begin
                        bit_cnt_d = bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd0) begin
                            sgl_d = sdi_q;
                        end else if (bit_cnt_q == 2'd1) begin
                            odd_d = sdi_q;
                        end else begin
                            // MSBF bit: the conversion is latched here
                            shift_d        = odd_q ? ch1_data : ch0_data;
                            conv_channel_d = odd_q;
                            conv_diff_d    = ~sgl_q;
                            conv_valid_d   = 1'b1;
`ifdef ADC_RESP_LSBF_EN
                            msbf_d         = sdi_q;
`endif
                            state_d        = S_NULL;
                        end
                    end
                end
                S_NULL: begin
                    if (sck_fall_q) begin
                        sdo_en_d = 1'b1;
                        sdo_d    = 1'b0;
                        idx_d    = IDX_LAST;
                        last_d   = 1'b0;
                        state_d  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (sck_fall_q) begin
                        if (last_q) begin
`ifdef ADC_RESP_LSBF_EN
                            if (!msbf_q) begin
                                sdo_d   = shift_q[1];
                                idx_d   = IDX_W'(2);
                                last_d  = (DATA_W <= 2);
                                state_d = S_TAIL;
                            end else begin
                                sdo_d    = 1'b0;
                                sdo_en_d = 1'b0;
                                state_d  = S_DONE;
                            end
`else
                            sdo_d    = 1'b0;
                            sdo_en_d = 1'b0;
                            state_d  = S_DONE;
`endif
                        end else begin
                            sdo_d = shift_q[idx_q];
                            if (idx_q == '0) begin
                                last_d = 1'b1;
                            end else begin
                                idx_d = idx_q - IDX_W'(1);
                            end
                        end
                    end
                end
`ifdef ADC_RESP_LSBF_EN
                S_TAIL: begin
                    if (sck_fall_q) begin
                        if (last_q) begin
                            sdo_d    = 1'b0;
                            sdo_en_d = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            sdo_d = shift_q[idx_q];
                            if (idx_q == IDX_LAST) begin
                                last_d = 1'b1;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
`endif
                S_DONE: begin
                    sdo_d    = 1'b0;
                    sdo_en_d = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    sdo_d    = 1'b0;
                    sdo_en_d = 1'b0;
                end
            endcase
        end
    end

    assign spi.sdata_from_adc = sdo_q;
    assign spi.sdo_en         = sdo_en_q;
    assign conv_valid         = conv_valid_q;
    assign conv_channel       = conv_channel_q;
    assign conv_diff          = conv_diff_q;
    assign frame_error        = frame_error_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: acts as an spi2adc master at 1 MHz
// SCK on a 50 MHz sysclk, captures the returned bits on SCK rising edges
// and compares them against hand-computed words.
module tb_spi_adc_responder;
    localparam int HALF = 25;   // sysclk cycles per SCK half-period
    localparam int DW   = 10;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic [DW-1:0] ch0_data, ch1_data;
    logic          conv_valid, conv_channel, conv_diff, frame_error;
    logic [2:0]    dbg_state;

    spi_adc_responder_if spi ();

    spi_adc_responder #(.SYNC_STAGES(2), .DATA_W(DW)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .spi          (spi),
        .ch0_data     (ch0_data),
        .ch1_data     (ch1_data),
        .conv_valid   (conv_valid),
        .conv_channel (conv_channel),
        .conv_diff    (conv_diff),
        .frame_error  (frame_error),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #10 sysclk = ~sysclk;

    // Scoreboard state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int            cv_total = 0;
    int            fe_total = 0;
    logic          cap_sdo[0:63];
    logic          cap_en[0:63];

    // Pulse monitor, sampled away from the active edge
    always @(negedge sysclk) begin
        if (conv_valid)  cv_total++;
        if (frame_error) fe_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One master frame: n_lead zeros, start bit, SGL, ODD, MSBF, then zeros.
    task automatic frame(input int n_lead, input logic sgl, input logic odd,
                         input logic msbf, input int n_clk, input int scramble_at,
                         input bit raise_cs);
        for (int i = 0; i < 64; i++) begin
            cap_sdo[i] = 1'b0;
            cap_en[i]  = 1'b0;
        end
        spi.adc_cs = 1'b0;
        repeat (HALF) @(negedge sysclk);
        for (int i = 0; i < n_clk; i++) begin
            logic b;
            if (i < n_lead)           b = 1'b0;
            else if (i == n_lead)     b = 1'b1;
            else if (i == n_lead + 1) b = sgl;
            else if (i == n_lead + 2) b = odd;
            else if (i == n_lead + 3) b = msbf;
            else                      b = 1'b0;
            spi.sdata_to_adc = b;
            repeat (HALF) @(negedge sysclk);
            cap_sdo[i]  = spi.sdata_from_adc;
            cap_en[i]   = spi.sdo_en;
            spi.adc_sck = 1'b1;
            if (i == scramble_at) begin
                ch0_data = ~ch0_data;
                ch1_data = ~ch1_data;
            end
            repeat (HALF) @(negedge sysclk);
            spi.adc_sck = 1'b0;
        end
        repeat (HALF) @(negedge sysclk);
        if (raise_cs) begin
            spi.adc_cs = 1'b1;
            repeat (3 * HALF) @(negedge sysclk);
        end
    endtask

    // Null bit, MSB-first data word and drive enable for a complete frame
    task automatic check_frame(input string tag, input int n_lead);
        logic [DW-1:0] w;
        logic [DW:0]   en;
        logic [DW-1:0] exp;
        for (int j = 0; j < DW; j++)  w[DW-1-j] = cap_sdo[n_lead + 5 + j];
        for (int j = 0; j <= DW; j++) en[DW-j]  = cap_en[n_lead + 4 + j];
        exp = exp_q.pop_front();
        check({tag, "_null"}, cap_sdo[n_lead + 4], 0);
        check({tag, "_data"}, w, exp);
        check({tag, "_en"}, en, 11'h7FF);
    endtask

    initial begin
        int cv0, fe0;
        logic [DW-1:0] abort_word;
        logic [8:0]    tail, tail_en;
        logic          any_en;

        spi.adc_cs       = 1'b1;
        spi.adc_sck      = 1'b0;
        spi.sdata_to_adc = 1'b0;
        ch0_data         = '0;
        ch1_data         = '0;

        // Reset
        repeat (4) @(negedge sysclk);
        check("rst_sdo", spi.sdata_from_adc, 0);
        check("rst_en", spi.sdo_en, 0);
        check("rst_cv", conv_valid, 0);
        check("rst_chan", conv_channel, 0);
        check("rst_diff", conv_diff, 0);
        check("rst_fe", frame_error, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge sysclk);

        // ch1 single-ended MSBF, 10'h2A5
        ch1_data = 10'h2A5; ch0_data = 10'h0C3;
        cv0 = cv_total; fe0 = fe_total;
        exp_q.push_back(10'h2A5);
        frame(0, 1'b1, 1'b1, 1'b1, 16, -1, 1'b1);
        check_frame("f1", 0);
        check("f1_en_done", cap_en[15], 0);
        check("f1_cv", cv_total - cv0, 1);
        check("f1_chan", conv_channel, 1);
        check("f1_diff", conv_diff, 0);
        check("f1_fe", fe_total - fe0, 0);
        check("f1_en_idle", spi.sdo_en, 0);

        // ch0 single-ended, all ones
        ch0_data = 10'h3FF; ch1_data = 10'h000;
        cv0 = cv_total;
        exp_q.push_back(10'h3FF);
        frame(0, 1'b1, 1'b0, 1'b1, 16, -1, 1'b1);
        check_frame("f2", 0);
        check("f2_cv", cv_total - cv0, 1);
        check("f2_chan", conv_channel, 0);

        // Three leading zeros; inputs change after the latch point
        ch1_data = 10'h155; ch0_data = 10'h2AA;
        fe0 = fe_total;
        exp_q.push_back(10'h155);
        frame(3, 1'b1, 1'b1, 1'b1, 19, 8, 1'b1);
        check_frame("f3", 3);
        check("f3_chan", conv_channel, 1);
        check("f3_fe", fe_total - fe0, 0);

        // Differential request on ch0
        ch0_data = 10'h13C; ch1_data = 10'h001;
        exp_q.push_back(10'h13C);
        frame(0, 1'b0, 1'b0, 1'b1, 16, -1, 1'b1);
        check_frame("f4", 0);
        check("f4_diff", conv_diff, 1);
        check("f4_chan", conv_channel, 0);

        // CS raised after the 6th data bit
        ch1_data = 10'h1E7;
        abort_word = 10'h1E7;
        fe0 = fe_total;
        frame(0, 1'b1, 1'b1, 1'b1, 11, -1, 1'b0);
        check("ab_bits", {cap_sdo[5], cap_sdo[6], cap_sdo[7], cap_sdo[8], cap_sdo[9], cap_sdo[10]},
              abort_word[9:4]);
        check("ab_en_pre", spi.sdo_en, 1);
        spi.adc_cs = 1'b1;
        repeat (4) @(negedge sysclk);
        check("ab_en_post", spi.sdo_en, 0);
        check("ab_sdo_post", spi.sdata_from_adc, 0);
        repeat (3 * HALF) @(negedge sysclk);
        check("ab_fe", fe_total - fe0, 1);
        ch0_data = 10'h0F0;
        exp_q.push_back(10'h0F0);
        frame(0, 1'b1, 1'b0, 1'b1, 16, -1, 1'b1);
        check_frame("f5", 0);

        // Reset mid-DATA with CS held low
        ch1_data = 10'h3A1;
        frame(0, 1'b1, 1'b1, 1'b1, 10, -1, 1'b0);
        check("mr_en_pre", spi.sdo_en, 1);
        rst_n = 1'b0;
        @(negedge sysclk);
        check("mr_sdo", spi.sdata_from_adc, 0);
        check("mr_en", spi.sdo_en, 0);
        check("mr_chan", conv_channel, 0);
        check("mr_diff", conv_diff, 0);
        check("mr_state", dbg_state, 0);
        rst_n = 1'b1;
        cv0 = cv_total; fe0 = fe_total;
        frame(0, 1'b1, 1'b1, 1'b1, 16, -1, 1'b1);
        any_en = 1'b0;
        for (int i = 0; i < 16; i++) any_en = any_en | cap_en[i];
        check("mr_no_cv", cv_total - cv0, 0);
        check("mr_no_en", any_en, 0);
        check("mr_no_fe", fe_total - fe0, 0);
        ch1_data = 10'h2C3;
        exp_q.push_back(10'h2C3);
        frame(0, 1'b1, 1'b1, 1'b1, 16, -1, 1'b1);
        check_frame("f6", 0);

        // MSBF=0 frame with extra clocks for the LSB-first tail
        ch1_data = 10'h201;
        exp_q.push_back(10'h201);
        frame(0, 1'b1, 1'b1, 1'b0, 25, -1, 1'b1);
        check_frame("f7", 0);
        for (int j = 0; j < 9; j++) begin
            tail[8-j]    = cap_sdo[15 + j];
            tail_en[8-j] = cap_en[15 + j];
        end
`ifdef ADC_RESP_LSBF_EN
        check("f7_tail", tail, 9'b000000001);
        check("f7_tail_en", tail_en, 9'h1FF);
        check("f7_en_done", cap_en[24], 0);
`else
        check("f7_tail", tail, 9'h000);
        check("f7_tail_en", tail_en, 9'h000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
